// File: rtl/debouncer_pkg.sv
// rtl/debouncer_pkg.sv - shared types and defaults for the push-button debouncer
`timescale 1ns/1ps
package debouncer_pkg;

    // IDLE: debounced level 0, PRESSED: debounced level 1.
    // The *_WAIT states count how long the sample has disagreed with that level.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam int STABLE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/debouncer_sync_2ff.sv
// rtl/debouncer_sync_2ff.sv - 1-bit two-flop synchronizer for the button input
//
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears both flops
//   d    in   asynchronous input level
//   q    out  synchronized level (second flop)
`timescale 1ns/1ps
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debouncer.sv
// rtl/debouncer.sv - push-button debouncer with press pulse and run/stop flag
//
// Ports:
//   clk    in   system clock, all logic on the rising edge
//   rst    in   synchronous active-high reset
//   btn    in   raw bouncy button level, active-high, asynchronous to clk
//   tecla  out  one-cycle pulse per confirmed press
//   stop   out  run/stop flag, toggles on each confirmed press
//
// Build option: DEBOUNCER_SYNC_EN selects a two-flop synchronizer on btn;
// without it a single input register is used (one cycle less latency).
`timescale 1ns/1ps
module debouncer
    import debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic tecla,
    output logic stop
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    deb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             press;

`ifdef DEBOUNCER_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (s)
    );
`else
    logic btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign s = btn_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tecla <= 1'b0;
            stop  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            tecla <= press;
            stop  <= stop ^ press;
        end
    end

    // The counter only advances while below CNT_MAX and is cleared on every
    // state change, so it can never wrap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press      = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press      = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - directed self-checking bench for debouncer
`timescale 1ns/1ps
module tb_debouncer;

`ifdef DEBOUNCER_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif
    localparam int S   = 16;
    localparam int LAT = SYNC_STAGES + S + 1;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic tecla;
    logic stop;

    debouncer #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .tecla (tecla),
        .stop  (stop)
    );

    always #10 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pulses;
    int   first;
    int   c0;
    logic dbl;
    logic prev_t = 1'b0;
    logic prev_stop = 1'b0;
    logic stop_before;
    logic stop_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock, sampled 1 ns after the rising edge; records pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tecla === 1'b1) begin
            if (prev_t === 1'b1) dbl = 1'b1;
            pulses++;
            if (first < 0) begin
                first       = cyc;
                stop_before = prev_stop;
                stop_at     = stop;
            end
        end
        prev_t    = tecla;
        prev_stop = stop;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        pulses      = 0;
        first       = -1;
        dbl         = 1'b0;
        stop_before = 1'bx;
        stop_at     = 1'bx;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        btn = 1'bx;

        // reset with btn undriven then toggling
        tick();
        chk("rst_tecla0", tecla, 0);
        chk("rst_stop0", stop, 0);
        btn = 1'b1;
        tick();
        chk("rst_tecla1", tecla, 0);
        chk("rst_stop1", stop, 0);
        btn = 1'b0;
        tick();
        chk("rst_tecla2", tecla, 0);
        chk("rst_stop2", stop, 0);

        // bounce rejection: short highs separated by lows
        rst = 1'b0;
        clr();
        btn = 1'b1; run(1); btn = 1'b0; run(1);
        btn = 1'b1; run(2); btn = 1'b0; run(1);
        btn = 1'b1; run(1); btn = 1'b0; run(1);
        btn = 1'b1; run(2); btn = 1'b0; run(1);
        run(30);
        chk("bounce_pulses", pulses, 0);
        chk("bounce_stop", stop, 0);

        // clean press
        clr();
        c0  = cyc;
        btn = 1'b1;
        run(50);
        chk("press1_pulses", pulses, 1);
        chk("press1_latency", first - c0, LAT);
        chk("press1_stop_before", stop_before, 0);
        chk("press1_stop_at", stop_at, 1);
        chk("press1_stop_end", stop, 1);
        chk("press1_no_double", dbl, 0);

        // bouncy release
        clr();
        btn = 1'b0; run(2);
        btn = 1'b1; run(1);
        btn = 1'b0; run(1);
        btn = 1'b1; run(2);
        btn = 1'b0; run(30);
        chk("release_pulses", pulses, 0);
        chk("release_stop", stop, 1);

        // second press
        clr();
        c0  = cyc;
        btn = 1'b1;
        run(50);
        chk("press2_pulses", pulses, 1);
        chk("press2_latency", first - c0, LAT);
        chk("press2_stop_before", stop_before, 1);
        chk("press2_stop_at", stop_at, 0);
        chk("press2_stop_end", stop, 0);
        chk("press2_no_double", dbl, 0);
        clr();
        btn = 1'b0;
        run(40);
        chk("release2_pulses", pulses, 0);

        // reset in the middle of the count, button stays held
        clr();
        btn = 1'b1;
        run(12);
        chk("midrst_pre_pulses", pulses, 0);
        rst = 1'b1;
        run(2);
        chk("midrst_tecla", tecla, 0);
        chk("midrst_stop", stop, 0);
        chk("midrst_rst_pulses", pulses, 0);
        rst = 1'b0;
        c0  = cyc;
        run(50);
        chk("midrst_post_pulses", pulses, 1);
        chk("midrst_latency", first - c0, LAT);
        chk("midrst_stop_end", stop, 1);
        clr();
        btn = 1'b0;
        run(40);
        chk("release3_pulses", pulses, 0);

        // boundary: one sample short of the window, then exactly the window
        clr();
        btn = 1'b1;
        run(S);
        btn = 1'b0;
        run(40);
        chk("short_pulses", pulses, 0);
        chk("short_stop", stop, 1);
        clr();
        c0  = cyc;
        btn = 1'b1;
        run(S + 1);
        btn = 1'b0;
        run(40);
        chk("exact_pulses", pulses, 1);
        chk("exact_latency", first - c0, LAT);
        chk("exact_stop", stop, 0);
        chk("exact_no_double", dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
